// File: rtl/btn_step_counter.sv
// Button/auto-tick driven modulo-4 up/down counter feeding the 2-bit seven-segment decoder.
// Synchronizes and debounces a raw pushbutton, detects press edges and prescales auto steps.
module btn_step_counter #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic dir,
  input  logic auto_en,
  input  logic clr,
  output logic A,
  output logic B,
  output logic step
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PCNT_MAX = PW'(TICK_DIV - 1);

  logic          s1, s2;
  logic          db, db_d;
  logic [DW-1:0] dcnt;
  logic [PW-1:0] pcnt;
  logic [1:0]    cnt;
  logic          press, tick, step_req;

  // NOTE: every register below uses non-blocking assignments so all state
  // updates see the pre-edge values, which is what makes the pipeline timing exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_d <= 1'b0;
      dcnt <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      db_d <= db;
      if (s2 == db) begin
        dcnt <= '0;
      end else if (dcnt == DCNT_MAX) begin
        db   <= s2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  assign press    = db & ~db_d;
  assign tick     = auto_en & (pcnt == PCNT_MAX);
  // A coincident press and tick collapse into a single step.
  assign step_req = press | tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (!auto_en || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // clr wins over a simultaneous step request; that request is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 2'd0;
      step <= 1'b0;
    end else if (clr) begin
      cnt  <= 2'd0;
      step <= 1'b0;
    end else if (step_req) begin
      cnt  <= dir ? (cnt - 2'd1) : (cnt + 2'd1);
      step <= 1'b1;
    end else begin
      step <= 1'b0;
    end
  end

  assign A = cnt[1];
  assign B = cnt[0];

endmodule
